// File: rtl/sarray_pkg.sv
// Shared encodings for the systolic-array tile load controller:
// instruction types, precision modes and controller FSM states.
package sarray_pkg;

  typedef enum logic [1:0] {
    TYPE_TMMA     = 2'd0,
    TYPE_PRELOADA = 2'd1,
    TYPE_PRELOADC = 2'd2,
    TYPE_RSVD     = 2'd3
  } tinst_type_e;

  typedef enum logic {
    PREC_FULL = 1'b0,
    PREC_HALF = 1'b1
  } prec_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sarray_rd_credit.sv
// Outstanding read-request counter; can_issue is low once MAX_OUT reads
// are in flight. Simultaneous issue and return leave the count unchanged.
module sarray_rd_credit #(
  parameter int MAX_OUT = 8,
  parameter int OUT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [OUT_W-1:0] count,
  output logic             can_issue
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + OUT_W'(1);
    end else if (dec && !inc) begin
      count <= count - OUT_W'(1);
    end
  end

  assign can_issue = (count < OUT_W'(MAX_OUT));

endmodule

// File: rtl/sarray_tile_ctrl.sv
// Tile load controller: issues strided AR requests for one tile, then steers
// returning R beats to the A double-buffer (PRELOADA) or the array (TMMA/PRELOADC).
module sarray_tile_ctrl
  import sarray_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int LOAD_W    = 256,
  parameter int NUM_BEATS = 64,
  parameter int STRIDE    = 256,
  parameter int MAX_OUT   = 8,
  parameter int CNT_W     = $clog2(NUM_BEATS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tinst_valid_i,
  output logic              tinst_ready_o,
  input  logic [1:0]        tinst_type_i,
  input  logic [ADDR_W-1:0] tinst_addr_i,
  input  logic              tinst_precision_i,
  input  logic              tinst_acc_i,
  output logic              ar_valid_o,
  input  logic              ar_ready_i,
  output logic [ADDR_W-1:0] ar_addr_o,
  input  logic              r_valid_i,
  output logic              r_ready_o,
  input  logic [LOAD_W-1:0] r_data_i,
  output logic              abuf_wr_valid_o,
  output logic              abuf_wr_bank_o,
  output logic [CNT_W-1:0]  abuf_wr_addr_o,
  output logic [LOAD_W-1:0] abuf_wr_data_o,
  output logic              abuf_rd_valid_o,
  output logic              abuf_rd_bank_o,
  output logic [CNT_W-1:0]  abuf_rd_addr_o,
  output logic              sa_valid_o,
  output logic [CNT_W-1:0]  sa_cnt_o,
  output logic [LOAD_W-1:0] sa_data_o,
  output logic              sa_acc_o,
  output logic              sa_precision_o,
  output logic              sa_type_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int BW    = CNT_W + 1;
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam logic [BW-1:0]     FULL_BEATS = BW'(NUM_BEATS);
  localparam logic [BW-1:0]     HALF_BEATS = BW'(NUM_BEATS / 2);
  localparam logic [ADDR_W-1:0] STRIDE_A   = ADDR_W'(STRIDE);

  state_e            state, state_nxt;
  tinst_type_e       type_q;
  logic [ADDR_W-1:0] base_q;
  logic              prec_q, acc_q;
  logic [BW-1:0]     ar_cnt, r_cnt, beats, beats_m1;
  logic [OUT_W-1:0]  outstanding;
  logic              can_issue;
  logic              wr_bank, rd_bank;
  logic              in_io, accept, start, ar_hs, r_hs, r_stray, is_a;

  assign in_io    = (state == ST_REQ) || (state == ST_DRAIN);
  assign accept   = tinst_valid_i && tinst_ready_o;
  assign start    = accept && (tinst_type_i != TYPE_RSVD);
  assign beats    = (prec_q == PREC_HALF) ? HALF_BEATS : FULL_BEATS;
  assign beats_m1 = beats - BW'(1);
  // A beat with nothing outstanding is not ours: flag it and drop it.
  assign r_hs     = r_valid_i && in_io && (outstanding != '0);
  assign r_stray  = r_valid_i && !r_hs;
  assign ar_hs    = ar_valid_o && ar_ready_i;
  assign is_a     = (type_q == TYPE_PRELOADA);

  sarray_rd_credit #(.MAX_OUT(MAX_OUT), .OUT_W(OUT_W)) u_credit (
    .clk       (clk),
    .rst       (rst),
    .clr       (start),
    .inc       (ar_hs),
    .dec       (r_hs),
    .count     (outstanding),
    .can_issue (can_issue)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    ar_valid_o = 1'b0;
    done_o     = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_REQ;
      ST_REQ: begin
        // A returning beat frees a credit in the same cycle it is consumed.
        ar_valid_o = (ar_cnt < beats) && (can_issue || r_hs);
        if (ar_valid_o && ar_ready_i && (ar_cnt == beats_m1)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (r_hs && (r_cnt == beats_m1)) state_nxt = ST_DONE;
      ST_DONE: begin
        done_o    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      type_q  <= TYPE_TMMA;
      base_q  <= '0;
      prec_q  <= 1'b0;
      acc_q   <= 1'b0;
      ar_cnt  <= '0;
      r_cnt   <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      if (start) begin
        type_q <= tinst_type_e'(tinst_type_i);
        base_q <= tinst_addr_i;
        prec_q <= tinst_precision_i;
        acc_q  <= tinst_acc_i;
        ar_cnt <= '0;
        r_cnt  <= '0;
      end else begin
        if (ar_hs) ar_cnt <= ar_cnt + BW'(1);
        if (r_hs)  r_cnt  <= r_cnt + BW'(1);
      end
      if ((accept && (tinst_type_i == TYPE_RSVD)) || r_stray) err_o <= 1'b1;
      // A freshly loaded bank becomes the read bank; the next load goes to the other.
      if ((state == ST_DONE) && is_a) begin
        rd_bank <= wr_bank;
        wr_bank <= !wr_bank;
      end
    end
  end

  assign tinst_ready_o   = (state == ST_IDLE);
  assign busy_o          = (state != ST_IDLE);
  assign r_ready_o       = in_io;
  assign ar_addr_o       = base_q + ADDR_W'(ar_cnt) * STRIDE_A;

  assign abuf_wr_valid_o = r_hs && is_a;
  assign abuf_wr_bank_o  = wr_bank;
  assign abuf_wr_addr_o  = r_cnt[CNT_W-1:0];
  assign abuf_wr_data_o  = r_data_i;

  assign sa_valid_o      = r_hs && !is_a;
  assign sa_cnt_o        = r_cnt[CNT_W-1:0];
  assign sa_data_o       = r_data_i;
  assign sa_acc_o        = acc_q;
  assign sa_precision_o  = prec_q;
  assign sa_type_o       = (type_q == TYPE_PRELOADC);

  assign abuf_rd_valid_o = sa_valid_o && (type_q == TYPE_TMMA);
  assign abuf_rd_bank_o  = rd_bank;
  assign abuf_rd_addr_o  = r_cnt[CNT_W-1:0];

endmodule

// File: tb/tb_sarray_tile_ctrl.sv
// Directed bench for sarray_tile_ctrl: a table of tile instructions run against
// a one-cycle-behind memory model, plus sequences for error and reset corners.
module tb_sarray_tile_ctrl;
  import sarray_pkg::*;

  localparam int ADDR_W = 64;
  localparam int LOAD_W = 256;
  localparam int CNT_W  = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              tinst_valid_i, tinst_ready_o;
  logic [1:0]        tinst_type_i;
  logic [ADDR_W-1:0] tinst_addr_i;
  logic              tinst_precision_i, tinst_acc_i;
  logic              ar_valid_o, ar_ready_i;
  logic [ADDR_W-1:0] ar_addr_o;
  logic              r_valid_i, r_ready_o;
  logic [LOAD_W-1:0] r_data_i;
  logic              abuf_wr_valid_o, abuf_wr_bank_o;
  logic [CNT_W-1:0]  abuf_wr_addr_o;
  logic [LOAD_W-1:0] abuf_wr_data_o;
  logic              abuf_rd_valid_o, abuf_rd_bank_o;
  logic [CNT_W-1:0]  abuf_rd_addr_o;
  logic              sa_valid_o;
  logic [CNT_W-1:0]  sa_cnt_o;
  logic [LOAD_W-1:0] sa_data_o;
  logic              sa_acc_o, sa_precision_o, sa_type_o;
  logic              busy_o, done_o, err_o;

  sarray_tile_ctrl dut (
    .clk(clk), .rst(rst),
    .tinst_valid_i(tinst_valid_i), .tinst_ready_o(tinst_ready_o), .tinst_type_i(tinst_type_i),
    .tinst_addr_i(tinst_addr_i), .tinst_precision_i(tinst_precision_i), .tinst_acc_i(tinst_acc_i),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i),
    .abuf_wr_valid_o(abuf_wr_valid_o), .abuf_wr_bank_o(abuf_wr_bank_o),
    .abuf_wr_addr_o(abuf_wr_addr_o), .abuf_wr_data_o(abuf_wr_data_o),
    .abuf_rd_valid_o(abuf_rd_valid_o), .abuf_rd_bank_o(abuf_rd_bank_o), .abuf_rd_addr_o(abuf_rd_addr_o),
    .sa_valid_o(sa_valid_o), .sa_cnt_o(sa_cnt_o), .sa_data_o(sa_data_o), .sa_acc_o(sa_acc_o),
    .sa_precision_o(sa_precision_o), .sa_type_o(sa_type_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [LOAD_W-1:0] act, input logic [LOAD_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [LOAD_W-1:0] mk_data(input logic [31:0] tag, input int i);
    logic [31:0] iv;
    iv = 32'(i);
    return {tag, iv, {6{iv ^ 32'hA5A5_0000}}};
  endfunction

  typedef struct {
    logic [1:0]  typ;
    logic [63:0] addr;
    logic        prec;
    logic        acc;
    logic [31:0] tag;
    int          beats;
    logic [63:0] addr1;   // expected address of the second AR
    logic        bank;    // write bank (PRELOADA) or read bank (TMMA)
    int          stall;   // cycles with R held off
    bit          slow;    // ar_ready low on odd cycles
  } vec_t;

  vec_t vecs[6];

  task automatic do_reset();
    rst = 1'b1;
    tinst_valid_i = 1'b0; tinst_type_i = 2'd0; tinst_addr_i = '0;
    tinst_precision_i = 1'b0; tinst_acc_i = 1'b0;
    ar_ready_i = 1'b0; r_valid_i = 1'b0; r_data_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic issue(input logic [1:0] typ, input logic [63:0] addr, input logic prec, input logic acc);
    @(posedge clk); #1;
    tinst_valid_i = 1'b1; tinst_type_i = typ; tinst_addr_i = addr;
    tinst_precision_i = prec; tinst_acc_i = acc;
    #1 chk("tinst_ready", tinst_ready_o, 1'b1);
    @(posedge clk); #1;
    tinst_valid_i = 1'b0;
  endtask

  task automatic run_inst(input vec_t v);
    int ar_n, r_n, pend, cyc, last_r;
    bit done_seen, prev_stall;
    logic [63:0] exp_a;
    issue(v.typ, v.addr, v.prec, v.acc);
    ar_n = 0; r_n = 0; pend = 0; cyc = 0; last_r = -10; done_seen = 0; prev_stall = 0;
    while (!done_seen && cyc < 1000) begin
      ar_ready_i = !(v.slow && (cyc % 2 == 1));
      r_valid_i  = (cyc >= v.stall) && (pend > 0);
      r_data_i   = mk_data(v.tag, r_n);
      #1;
      if (prev_stall) chk("ar_hold", ar_valid_o, 1'b1);
      if (v.stall > 0 && cyc == v.stall - 1) chk("ar_credit_stop", ar_valid_o, 1'b0);
      if (v.stall > 0 && cyc == v.stall) begin
        chk("ar_credit_cnt", ar_n, 8);
        chk("ar_same_cycle", ar_valid_o, 1'b1);
      end
      if (ar_valid_o) begin
        exp_a = v.addr + 64'(ar_n) * 64'd256;
        chk("ar_addr", ar_addr_o, exp_a);
        if (ar_n == 1) chk("ar_addr1", ar_addr_o, v.addr1);
      end
      if (r_valid_i) begin
        chk("r_ready", r_ready_o, 1'b1);
        if (v.typ == TYPE_PRELOADA) begin
          chk("wr_valid", abuf_wr_valid_o, 1'b1);
          chk("wr_bank", abuf_wr_bank_o, v.bank);
          chk("wr_addr", abuf_wr_addr_o, r_n);
          chk("wr_data", abuf_wr_data_o, mk_data(v.tag, r_n));
          chk("wr_no_sa", sa_valid_o, 1'b0);
        end else begin
          chk("sa_valid", sa_valid_o, 1'b1);
          chk("sa_cnt", sa_cnt_o, r_n);
          chk("sa_data", sa_data_o, mk_data(v.tag, r_n));
          chk("sa_acc", sa_acc_o, v.acc);
          chk("sa_prec", sa_precision_o, v.prec);
          chk("sa_type", sa_type_o, v.typ == TYPE_PRELOADC);
          chk("rd_valid", abuf_rd_valid_o, v.typ == TYPE_TMMA);
          if (v.typ == TYPE_TMMA) begin
            chk("rd_bank", abuf_rd_bank_o, v.bank);
            chk("rd_addr", abuf_rd_addr_o, r_n);
          end
          chk("sa_no_wr", abuf_wr_valid_o, 1'b0);
        end
        r_n++; pend--; last_r = cyc;
      end else begin
        chk("quiet_wr", abuf_wr_valid_o, 1'b0);
        chk("quiet_sa", sa_valid_o, 1'b0);
      end
      if (done_o) begin
        done_seen = 1;
        chk("done_time", cyc, last_r + 1);
        chk("done_beats", r_n, v.beats);
      end
      prev_stall = ar_valid_o && !ar_ready_i;
      if (ar_valid_o && ar_ready_i) begin ar_n++; pend++; end
      @(posedge clk); #1;
      cyc++;
    end
    r_valid_i = 1'b0;
    chk("done_seen", done_seen, 1'b1);
    chk("ar_total", ar_n, v.beats);
    chk("r_total", r_n, v.beats);
    chk("done_pulse", done_o, 1'b0);
    chk("idle_busy", busy_o, 1'b0);
    chk("no_err", err_o, 1'b0);
  endtask

  initial begin
    int pend, ar_n, cyc;
    vecs[0] = '{typ:2'd1, addr:64'h1000, prec:1'b0, acc:1'b0, tag:32'h1111_0001, beats:64,
                addr1:64'h1100, bank:1'b0, stall:0, slow:1'b0};
    vecs[1] = '{typ:2'd0, addr:64'h2000, prec:1'b1, acc:1'b1, tag:32'h2222_0002, beats:32,
                addr1:64'h2100, bank:1'b0, stall:0, slow:1'b0};
    vecs[2] = '{typ:2'd1, addr:64'h8000, prec:1'b1, acc:1'b0, tag:32'h3333_0003, beats:32,
                addr1:64'h8100, bank:1'b1, stall:0, slow:1'b0};
    vecs[3] = '{typ:2'd0, addr:64'hFFFF_FFFF_FFFF_FF00, prec:1'b0, acc:1'b0, tag:32'h4444_0004, beats:64,
                addr1:64'h0, bank:1'b1, stall:0, slow:1'b0};
    vecs[4] = '{typ:2'd2, addr:64'h0, prec:1'b0, acc:1'b1, tag:32'h5555_0005, beats:64,
                addr1:64'h100, bank:1'b0, stall:0, slow:1'b1};
    vecs[5] = '{typ:2'd0, addr:64'h3000, prec:1'b1, acc:1'b0, tag:32'h6666_0006, beats:32,
                addr1:64'h3100, bank:1'b1, stall:20, slow:1'b0};

    do_reset();
    #1;
    chk("rst_ready", tinst_ready_o, 1'b1);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_ar_valid", ar_valid_o, 1'b0);
    chk("rst_r_ready", r_ready_o, 1'b0);
    chk("rst_sa_valid", sa_valid_o, 1'b0);
    chk("rst_wr_valid", abuf_wr_valid_o, 1'b0);
    chk("rst_rd_valid", abuf_rd_valid_o, 1'b0);

    for (int i = 0; i < 6; i++) run_inst(vecs[i]);

    // Stray R beat in IDLE is dropped and flagged.
    do_reset();
    @(posedge clk); #1;
    r_valid_i = 1'b1; r_data_i = mk_data(32'hDEAD_0000, 0);
    #1;
    chk("stray_r_ready", r_ready_o, 1'b0);
    chk("stray_sa", sa_valid_o, 1'b0);
    chk("stray_wr", abuf_wr_valid_o, 1'b0);
    chk("stray_err_pre", err_o, 1'b0);
    @(posedge clk); #1;
    r_valid_i = 1'b0;
    chk("stray_err", err_o, 1'b1);
    chk("stray_busy", busy_o, 1'b0);

    // Reserved type flags an error and issues nothing.
    do_reset();
    #1 chk("rsvd_err_pre", err_o, 1'b0);
    ar_ready_i = 1'b1;
    issue(2'd3, 64'h4000, 1'b0, 1'b0);
    chk("rsvd_err", err_o, 1'b1);
    chk("rsvd_busy", busy_o, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("rsvd_no_ar", ar_valid_o, 1'b0);
      @(posedge clk); #1;
    end

    // Reset while draining with three beats outstanding.
    do_reset();
    ar_ready_i = 1'b1;
    issue(2'd1, 64'h5000, 1'b1, 1'b0);
    pend = 0; ar_n = 0; cyc = 0;
    while (!(ar_n == 32 && pend == 3) && cyc < 300) begin
      r_valid_i = (pend > 3);
      r_data_i  = mk_data(32'h7777_0007, cyc);
      #1;
      if (ar_valid_o && ar_ready_i) begin ar_n++; pend++; end
      if (r_valid_i) pend--;
      @(posedge clk); #1;
      cyc++;
    end
    r_valid_i = 1'b0;
    #1;
    chk("drain_reached", cyc < 300, 1'b1);
    chk("drain_busy", busy_o, 1'b1);
    chk("drain_no_ar", ar_valid_o, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_ready", tinst_ready_o, 1'b1);
    chk("mid_rst_r_ready", r_ready_o, 1'b0);
    chk("mid_rst_done", done_o, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_err", err_o, 1'b0);
    for (int i = 0; i < 3; i++) begin
      r_valid_i = 1'b1;
      #1;
      chk("late_r_wr", abuf_wr_valid_o, 1'b0);
      chk("late_r_done", done_o, 1'b0);
      @(posedge clk); #1;
    end
    r_valid_i = 1'b0;
    chk("late_r_err", err_o, 1'b1);
    chk("late_r_busy", busy_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
